// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing a cleared-on-reset single-port RAM between two requesters
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req_valid/we/addr/wdata_{0,1}   request channel per requester
//   req_ready_{0,1}                 request accepted this cycle when valid & ready
//   rsp_valid_{0,1}, rsp_rdata      one-cycle read response pulse, shared data bus
//   init_done                       high once every word has been zeroed
module ram_port_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_0,
  input  logic                  req_we_0,
  input  logic [DEPTH_LOG2-1:0] req_addr_0,
  input  logic [WORD_SIZE-1:0]  req_wdata_0,
  input  logic                  req_valid_1,
  input  logic                  req_we_1,
  input  logic [DEPTH_LOG2-1:0] req_addr_1,
  input  logic [WORD_SIZE-1:0]  req_wdata_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic [WORD_SIZE-1:0]  rsp_rdata,
  output logic                  init_done
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;
  state_t                  r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0]   r_clr_cnt;
  logic                    r_last_grant;
  logic [WORD_SIZE-1:0]    r_mem [2**DEPTH_LOG2];
  logic [1:0]              r_rsp_valid;
  logic [WORD_SIZE-1:0]    r_rsp_rdata;
  logic                    w_gnt_0, w_gnt_1, w_acc, w_we;
  logic [DEPTH_LOG2-1:0]   w_addr;
  logic [WORD_SIZE-1:0]    w_wdata;
  always_comb begin
    // on a tie the requester that did not win last time goes first
    w_gnt_0     = req_valid_0 && (!req_valid_1 || r_last_grant);
    w_gnt_1     = req_valid_1 && (!req_valid_0 || !r_last_grant);
    req_ready_0 = (r_state == RUN) && w_gnt_0;
    req_ready_1 = (r_state == RUN) && w_gnt_1;
    w_acc       = req_ready_0 || req_ready_1;
    w_we        = req_ready_1 ? req_we_1    : req_we_0;
    w_addr      = req_ready_1 ? req_addr_1  : req_addr_0;
    w_wdata     = req_ready_1 ? req_wdata_1 : req_wdata_0;
    w_state_nxt = (r_state == INIT && r_clr_cnt == LAST_ADDR) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_clr_cnt    <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (r_state == INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_acc) r_last_grant <= req_ready_1;
      r_rsp_valid <= {req_ready_1 && !w_we, req_ready_0 && !w_we};
      if (w_acc && !w_we) r_rsp_rdata <= r_mem[w_addr];
    end
  end
  // storage has no reset of its own; the INIT pass zeroes it and a reset edge blocks any write
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == INIT) r_mem[r_clr_cnt] <= '0;
      else if (w_acc && w_we) r_mem[w_addr] <= w_wdata;
    end
  end
  assign rsp_valid_0 = r_rsp_valid[0];
  assign rsp_valid_1 = r_rsp_valid[1];
  assign rsp_rdata   = r_rsp_rdata;
  assign init_done   = (r_state == RUN);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven, directed and randomized checks of ram_port_arbiter against a cycle model
module tb_ram_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        v0, we0, v1, we1;
  logic [2:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, rv0, rv1, done;
  logic [31:0] rdata;
  int n_pass = 0, n_total = 0;
  logic [31:0] m_mem [8];
  logic [31:0] m_rdata;
  int m_last, m_cnt, m_win;
  bit m_run, m_rv0, m_rv1;
  typedef struct {
    logic v0, we0; logic [2:0] a0; logic [31:0] d0;
    logic v1, we1; logic [2:0] a1; logic [31:0] d1;
    logic r0, r1, rv0, rv1; logic [31:0] rd;
  } vec_t;
  vec_t tbl [12];
  logic [31:0] sx [4];
  always #5 clk = ~clk;
  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid_0(v0), .req_we_0(we0), .req_addr_0(a0), .req_wdata_0(d0),
    .req_valid_1(v1), .req_we_1(we1), .req_addr_1(a1), .req_wdata_1(d1),
    .req_ready_0(rdy0), .req_ready_1(rdy1),
    .rsp_valid_0(rv0), .rsp_valid_1(rv1), .rsp_rdata(rdata), .init_done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask
  task automatic set_req(input logic iv0, iwe0, input logic [2:0] ia0, input logic [31:0] id0,
                         input logic iv1, iwe1, input logic [2:0] ia1, input logic [31:0] id1);
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
  endtask
  task automatic idle();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // compare the outputs of the current cycle with what the model predicts
  task automatic check_model();
    @(negedge clk);
    m_win = -1;
    if (m_run) m_win = (v0 && v1) ? 1 - m_last : v0 ? 0 : v1 ? 1 : -1;
    chk("ready_0", rdy0, m_win == 0);
    chk("ready_1", rdy1, m_win == 1);
    chk("rsp_valid_0", rv0, m_rv0);
    chk("rsp_valid_1", rv1, m_rv1);
    chk("rsp_rdata", rdata, m_rdata);
    chk("init_done", done, m_run);
  endtask
  // advance the model across the rising edge
  task automatic tick();
    @(posedge clk);
    m_rv0 = 0;
    m_rv1 = 0;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_last = 1; m_rdata = 0;
    end else if (!m_run) begin
      m_mem[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 8) m_run = 1;
    end else if (m_win == 0) begin
      m_last = 0;
      if (we0) m_mem[a0] = d0;
      else begin m_rdata = m_mem[a0]; m_rv0 = 1; end
    end else if (m_win == 1) begin
      m_last = 1;
      if (we1) m_mem[a1] = d1;
      else begin m_rdata = m_mem[a1]; m_rv1 = 1; end
    end
    #1;
  endtask
  task automatic step();
    check_model();
    tick();
  endtask
  task automatic read_zero_sweep(input string tag);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_req(1, 0, i[2:0], 0, 0, 0, 0, 0);
      else idle();
      check_model();
      if (i < 8) chk({tag, "_rdy0"}, rdy0, 1);
      if (i > 0) begin
        chk({tag, "_rv0"}, rv0, 1);
        chk({tag, "_zero"}, rdata, 0);
      end
      tick();
    end
  endtask
  initial begin
    tbl[0]  = '{1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0,            1, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 3, 0,            0, 0, 0, 0,            1, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 0, 0, 0,            1, 1, 5, 32'h12345678, 0, 1, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 5, 0,            0, 0, 0, 0,            1, 0, 0, 0, 32'hDEADBEEF};
    tbl[4]  = '{0, 0, 0, 0,            1, 1, 2, 32'hA5A5A5A5, 0, 1, 1, 0, 32'h12345678};
    tbl[5]  = '{1, 0, 1, 0,            1, 0, 2, 0,            1, 0, 0, 0, 32'h12345678};
    tbl[6]  = '{1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 1, 0, 32'h0};
    tbl[7]  = '{1, 0, 1, 0,            1, 0, 2, 0,            1, 0, 0, 1, 32'hA5A5A5A5};
    tbl[8]  = '{1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 1, 0, 32'h0};
    tbl[9]  = '{1, 0, 1, 0,            1, 0, 2, 0,            1, 0, 0, 1, 32'hA5A5A5A5};
    tbl[10] = '{1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 1, 0, 32'h0};
    tbl[11] = '{0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 1, 32'hA5A5A5A5};
    sx = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF};
    m_run = 0; m_cnt = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0; m_rdata = 0; m_win = -1;
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    step();
    reset = 0;
    set_req(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check_model();
      chk("init_no_ready", {rdy1, rdy0}, 0);
      chk("init_done_low", done, 0);
      tick();
    end
    check_model();
    chk("init_done_rise", done, 1);
    chk("first_tie_r0", rdy0, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_req(1, 1, i[2:0], 32'hFFFFFFFF, 0, 0, 0, 0);
      step();
    end
    idle();
    reset = 1;
    repeat (2) step();
    reset = 0;
    set_req(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check_model();
      chk("clear_no_ready", rdy0, 0);
      tick();
    end
    read_zero_sweep("clear");
    idle();
    step();
    for (int i = 0; i < 12; i++) begin
      set_req(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      check_model();
      chk($sformatf("tbl%0d_ready0", i), rdy0, tbl[i].r0);
      chk($sformatf("tbl%0d_ready1", i), rdy1, tbl[i].r1);
      chk($sformatf("tbl%0d_rv0", i), rv0, tbl[i].rv0);
      chk($sformatf("tbl%0d_rv1", i), rv1, tbl[i].rv1);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_req(0, 0, 0, 0, 1, 0, k[2:0], 0);
      else idle();
      check_model();
      if (k < 4) chk("stream_rdy1", rdy1, 1);
      if (k > 0) begin
        chk("stream_rv1", rv1, 1);
        chk("stream_data", rdata, sx[k-1]);
      end
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      set_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
      step();
    end
    reset = 0;
    idle();
    repeat (10) step();
    set_req(1, 1, 3, 32'hCAFEF00D, 0, 0, 0, 0);
    step();
    set_req(1, 0, 3, 0, 0, 0, 0, 0);
    check_model();
    chk("mid_acc_rdy0", rdy0, 1);
    tick();
    reset = 1;
    idle();
    check_model();
    chk("mid_rsp_data", rdata, 32'hCAFEF00D);
    tick();
    reset = 0;
    set_req(1, 0, 0, 0, 1, 0, 0, 0);
    check_model();
    chk("mid_rv0_cleared", rv0, 0);
    chk("mid_init_dropped", done, 0);
    tick();
    repeat (7) step();
    check_model();
    chk("mid_tie_r0", rdy0, 1);
    chk("mid_tie_r1", rdy1, 0);
    tick();
    read_zero_sweep("mid");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
